// File: rtl/control_pkg.sv
// Shared encodings for the multi-cycle main controller: opcodes, ALUop codes,
// FSM states and the execution path selected by the opcode decoder.
package control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [2:0] ALUOP_RTYPE = 3'b111;
  localparam logic [2:0] ALUOP_ANDI  = 3'b110;
  localparam logic [2:0] ALUOP_ORI   = 3'b101;
  localparam logic [2:0] ALUOP_ADDI  = 3'b100;
  localparam logic [2:0] ALUOP_SLTI  = 3'b010;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_ADD   = 3'b000;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    TRAP
  } state_t;

  // Where the instruction goes after EXEC.
  typedef enum logic [2:0] {
    PATH_WB,
    PATH_LOAD,
    PATH_STORE,
    PATH_BRANCH,
    PATH_NOP
  } path_t;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode map: opcode -> ALUop, operand/destination selects,
// execution path and an illegal flag for unsupported opcodes.
module opcode_decoder
  import control_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic [2:0]          aluop,
  output logic                alu_src,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output path_t               path,
  output logic                illegal
);

  always_comb begin
    aluop      = ALUOP_ADD;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    path       = PATH_NOP;
    illegal    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        aluop   = ALUOP_RTYPE;
        reg_dst = 1'b1;
        path    = PATH_WB;
      end
      OP_ANDI: begin
        aluop   = ALUOP_ANDI;
        alu_src = 1'b1;
        path    = PATH_WB;
      end
      OP_ORI: begin
        aluop   = ALUOP_ORI;
        alu_src = 1'b1;
        path    = PATH_WB;
      end
      OP_ADDI: begin
        aluop   = ALUOP_ADDI;
        alu_src = 1'b1;
        path    = PATH_WB;
      end
      OP_SLTI: begin
        aluop   = ALUOP_SLTI;
        alu_src = 1'b1;
        path    = PATH_WB;
      end
      OP_LW: begin
        aluop      = ALUOP_ADD;
        alu_src    = 1'b1;
        mem_to_reg = 1'b1;
        path       = PATH_LOAD;
      end
      OP_SW: begin
        aluop   = ALUOP_ADD;
        alu_src = 1'b1;
        path    = PATH_STORE;
      end
      OP_BEQ: begin
        aluop = ALUOP_SUB;
        path  = PATH_BRANCH;
      end
      default: begin
        // Unsupported opcode behaves as a NOP with ALUop=ADD.
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multi-cycle datapath (FETCH/DECODE/EXEC/MEM/WB).
// Define ILLEGAL_TRAP_EN to lock up in TRAP on an unsupported opcode.
module multicycle_main_control
  import control_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int FUNCT_W  = 6,
  parameter int ALUOP_W  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                mem_ready,
  output logic [ALUOP_W-1:0]  ALUop,
  output logic [FUNCT_W-1:0]  function_code,
  output logic                alu_src,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                branch,
  output logic                busy,
  output logic                illegal
);

  state_t                state_reg, state_next;
  logic [OPCODE_W-1:0]   opcode_reg;
  logic [FUNCT_W-1:0]    funct_reg;
  logic [ALUOP_W-1:0]    aluop_reg;
  logic [FUNCT_W-1:0]    function_code_reg;
  logic                  alu_src_reg;
  logic                  reg_dst_reg;
  logic                  mem_to_reg_reg;

  logic [2:0]            dec_aluop;
  logic                  dec_alu_src;
  logic                  dec_reg_dst;
  logic                  dec_mem_to_reg;
  path_t                 dec_path;
  logic                  dec_illegal;
  logic                  accept;

  // The decoder always looks at the captured opcode, so its path stays valid
  // for the whole instruction and steers EXEC/MEM without extra registers.
  opcode_decoder #(
    .OPCODE_W (OPCODE_W)
  ) u_opcode_decoder (
    .opcode     (opcode_reg),
    .aluop      (dec_aluop),
    .alu_src    (dec_alu_src),
    .reg_dst    (dec_reg_dst),
    .mem_to_reg (dec_mem_to_reg),
    .path       (dec_path),
    .illegal    (dec_illegal)
  );

  assign accept = instr_valid && (state_reg == FETCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= FETCH;
      opcode_reg        <= '0;
      funct_reg         <= '0;
      aluop_reg         <= '0;
      function_code_reg <= '0;
      alu_src_reg       <= 1'b0;
      reg_dst_reg       <= 1'b0;
      mem_to_reg_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        opcode_reg <= opcode;
        funct_reg  <= funct;
      end
      // Decoded controls load at the end of DECODE and hold until the next one.
      if (state_reg == DECODE) begin
        aluop_reg         <= ALUOP_W'(dec_aluop);
        function_code_reg <= dec_reg_dst ? funct_reg : '0;
        alu_src_reg       <= dec_alu_src;
        reg_dst_reg       <= dec_reg_dst;
        mem_to_reg_reg    <= dec_mem_to_reg;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    instr_ready = 1'b0;
    busy        = 1'b1;
    reg_write   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    branch      = 1'b0;
    illegal     = 1'b0;
    case (state_reg)
      FETCH: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        if (instr_valid) begin
          state_next = DECODE;
        end
      end
      DECODE: begin
        illegal = dec_illegal;
`ifdef ILLEGAL_TRAP_EN
        state_next = dec_illegal ? TRAP : EXEC;
`else
        state_next = EXEC;
`endif
      end
      EXEC: begin
        illegal = dec_illegal;
        branch  = (dec_path == PATH_BRANCH);
        case (dec_path)
          PATH_WB:                state_next = WB;
          PATH_LOAD, PATH_STORE:  state_next = MEM;
          default:                state_next = FETCH;
        endcase
      end
      MEM: begin
        mem_read  = (dec_path == PATH_LOAD);
        mem_write = (dec_path == PATH_STORE);
        if (mem_ready) begin
          state_next = (dec_path == PATH_LOAD) ? WB : FETCH;
        end
      end
      WB: begin
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      TRAP: begin
        // Only rst_n leaves this state.
        illegal = 1'b1;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  assign ALUop         = aluop_reg;
  assign function_code = function_code_reg;
  assign alu_src       = alu_src_reg;
  assign reg_dst       = reg_dst_reg;
  assign mem_to_reg    = mem_to_reg_reg;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench for multicycle_main_control: directed instructions push
// hand-computed expectations; a forked monitor measures each instruction.
module tb_multicycle_main_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       mem_ready = 1'b1;
  logic [2:0] ALUop;
  logic [5:0] function_code;
  logic       alu_src, reg_dst, mem_to_reg, reg_write;
  logic       mem_read, mem_write, branch, busy, illegal;

  multicycle_main_control dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .opcode        (opcode),
    .funct         (funct),
    .mem_ready     (mem_ready),
    .ALUop         (ALUop),
    .function_code (function_code),
    .alu_src       (alu_src),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .branch        (branch),
    .busy          (busy),
    .illegal       (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] aluop;
    logic [5:0] fc;
    logic       alu_src;
    logic       reg_dst;
    logic       mtr;
    int         rw, mr, mw, br, il, lat, idle;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   mem_delay = 0;
  int   mem_cnt = 0;

  // Memory model: mem_ready rises after mem_delay waiting cycles of a request;
  // outside a request it is held high to show it is ignored there.
  always @(negedge clk) begin
    if (mem_read || mem_write) begin
      mem_ready = (mem_cnt == mem_delay);
      mem_cnt   = mem_cnt + 1;
    end else begin
      mem_cnt   = 0;
      mem_ready = 1'b1;
    end
  end

  bit         m_active = 0;
  int         m_n = 0, m_cyc, m_rw, m_mr, m_mw, m_br, m_il, m_idle = 0, m_start_idle;
  logic [2:0] m_aluop;
  logic [5:0] m_fc;
  logic       m_alu_src, m_reg_dst, m_mtr;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int out_vec();
    return int'({instr_ready, busy, illegal, reg_write, mem_read, mem_write, branch,
                 alu_src, reg_dst, mem_to_reg, ALUop, function_code});
  endfunction

  task automatic finish_txn();
    exp_t e;
    string t;
    t = $sformatf("txn%0d", m_n);
    if (exp_q.size() == 0) begin
      check({t, " unexpected_txn"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({t, " latency"}, m_cyc, e.lat);
      check({t, " ALUop"}, int'(m_aluop), int'(e.aluop));
      check({t, " function_code"}, int'(m_fc), int'(e.fc));
      check({t, " alu_src"}, int'(m_alu_src), int'(e.alu_src));
      check({t, " reg_dst"}, int'(m_reg_dst), int'(e.reg_dst));
      check({t, " reg_write_cycles"}, m_rw, e.rw);
      check({t, " mem_read_cycles"}, m_mr, e.mr);
      check({t, " mem_write_cycles"}, m_mw, e.mw);
      check({t, " branch_cycles"}, m_br, e.br);
      check({t, " illegal_cycles"}, m_il, e.il);
      if (e.rw > 0) check({t, " mem_to_reg_at_wb"}, int'(m_mtr), int'(e.mtr));
      if (e.idle >= 0) check({t, " fetch_cycles_before_accept"}, m_start_idle, e.idle);
    end
    $display("txn %0d: lat=%0d ALUop=%b fc=%b rw=%0d mr=%0d mw=%0d br=%0d il=%0d",
             m_n, m_cyc, m_aluop, m_fc, m_rw, m_mr, m_mw, m_br, m_il);
    m_n++;
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_active = 0;
        m_idle   = 0;
      end else begin
        if (m_active) begin
          if (busy) begin
            m_cyc++;
            m_rw += reg_write ? 1 : 0;
            m_mr += mem_read  ? 1 : 0;
            m_mw += mem_write ? 1 : 0;
            m_br += branch    ? 1 : 0;
            m_il += illegal   ? 1 : 0;
            if (m_cyc == 2) begin
              m_aluop   = ALUop;
              m_fc      = function_code;
              m_alu_src = alu_src;
              m_reg_dst = reg_dst;
            end
            if (reg_write) m_mtr = mem_to_reg;
          end else begin
            finish_txn();
            m_active = 0;
            m_idle   = 0;
          end
        end
        if (instr_ready) begin
          m_idle++;
          if (instr_valid) begin
            m_active = 1;
            m_cyc = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_br = 0; m_il = 0;
            m_aluop = '0; m_fc = '0; m_alu_src = 0; m_reg_dst = 0; m_mtr = 0;
            m_start_idle = m_idle;
          end
        end
      end
    end
  endtask

  task automatic expect_txn(input logic [2:0] aluop, input logic [5:0] fc,
                            input logic as, input logic rd, input logic mtr,
                            input int rw, input int mr, input int mw, input int br,
                            input int il, input int lat, input int idle);
    exp_t e;
    e.aluop = aluop; e.fc = fc; e.alu_src = as; e.reg_dst = rd; e.mtr = mtr;
    e.rw = rw; e.mr = mr; e.mw = mw; e.br = br; e.il = il; e.lat = lat; e.idle = idle;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input int delay);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!instr_ready && n < 100);
    check("accept_wait", int'(instr_ready), 1);
    mem_delay   = delay;
    opcode      = op;
    funct       = fn;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    opcode      = 6'($urandom);
    funct       = 6'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  rw_seen;
    bit  stuck_ok;
    fork
      monitor_loop();
    join_none

    repeat (2) @(posedge clk);
    #1 check("reset_outputs", out_vec(), 1 << 18);
    @(posedge clk); #2 rst_n = 1'b1;

    expect_txn(3'b111, 6'b000011, 0, 1, 0, 1, 0, 0, 0, 0, 3, -1);
    issue(6'b000000, 6'b000011, 0);
    expect_txn(3'b110, 6'b000000, 1, 0, 0, 1, 0, 0, 0, 0, 3, 1);
    issue(6'b001100, 6'b000010, 0);
    expect_txn(3'b000, 6'b000000, 1, 0, 1, 1, 3, 0, 0, 0, 6, 1);
    issue(6'b100011, 6'b000101, 2);
    expect_txn(3'b000, 6'b000000, 1, 0, 0, 0, 0, 1, 0, 0, 3, 1);
    issue(6'b101011, 6'b000000, 0);
    expect_txn(3'b001, 6'b000000, 0, 0, 0, 0, 0, 0, 1, 0, 2, 1);
    issue(6'b000100, 6'b101010, 0);
    expect_txn(3'b101, 6'b000000, 1, 0, 0, 1, 0, 0, 0, 0, 3, 1);
    issue(6'b001101, 6'b111111, 0);
    expect_txn(3'b010, 6'b000000, 1, 0, 0, 1, 0, 0, 0, 0, 3, 1);
    issue(6'b001010, 6'b000001, 0);
`ifndef ILLEGAL_TRAP_EN
    expect_txn(3'b000, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 2, 2, 1);
    issue(6'b111111, 6'b000011, 0);
`endif
    expect_txn(3'b111, 6'b100000, 0, 1, 0, 1, 0, 0, 0, 0, 3, 1);
    issue(6'b000000, 6'b100000, 0);
    expect_txn(3'b000, 6'b000000, 1, 0, 0, 0, 0, 2, 0, 0, 4, 1);
    issue(6'b101011, 6'b000000, 1);
    drain();

    // lw parked in MEM, then reset: strobes must drop at once, no write later.
    issue(6'b100011, 6'b000000, 20);
    n = 0;
    while (!mem_read && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("lw_reached_mem", int'(mem_read), 1);
    #2 rst_n = 1'b0;
    #1 check("reset_mid_lw_outputs", out_vec(), 1 << 18);
    @(posedge clk); #2 rst_n = 1'b1;
    rw_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (reg_write || busy) rw_seen = 1;
    end
    check("no_activity_after_reset", int'(rw_seen), 0);

    expect_txn(3'b100, 6'b000000, 1, 0, 0, 1, 0, 0, 0, 0, 3, -1);
    issue(6'b001000, 6'b010101, 0);
    drain();

`ifdef ILLEGAL_TRAP_EN
    issue(6'b111111, 6'b000000, 0);
    stuck_ok = 1;
    repeat (12) begin
      @(negedge clk);
      if (!busy || instr_ready || !illegal || reg_write || mem_read || mem_write || branch)
        stuck_ok = 0;
    end
    check("trap_stuck", int'(stuck_ok), 1);
    #1 rst_n = 1'b0;
    #1 check("trap_reset_outputs", out_vec(), 1 << 18);
    @(posedge clk); #2 rst_n = 1'b1;
`else
    stuck_ok = 1;
    check("trap_build_off", int'(stuck_ok), int'(instr_ready));
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
